approx_product_accumulator: RTL and testbench

//   Downstream consumer of the 4x4 approximate multiplier in each systolic PE. Accepts a

---
 rtl/approx_sa_pkg.sv | 16 +
 rtl/sat_add_u.sv | 26 ++
 rtl/approx_product_accumulator.sv | 113 +++++++++++
 tb/tb_approx_product_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_sa_pkg.sv
// Shared definitions for the approximate systolic-array datapath.
//   acc_state_t : accumulator FSM states (IDLE -> ACC -> OUT)
//   PROD_W_DEF  : default product width (approximate multiplier output)
//   ACC_W_DEF   : default accumulator / result width
package approx_sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } acc_state_t;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

endpackage

// File: rtl/sat_add_u.sv
// Unsigned ACC_W-bit adder with optional saturation.
//   a, b : unsigned addends
//   sum  : a+b, clamped to all-ones on carry when SAT=1, low ACC_W bits otherwise
//   ovf  : carry out of the ACC_W-bit sum
module sat_add_u #(
  parameter int ACC_W = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[ACC_W];
    if (SAT && full[ACC_W]) sum = '1;
    else                    sum = full[ACC_W-1:0];
  end

endmodule

// File: rtl/approx_product_accumulator.sv
// Accumulates up to K unsigned approximate products per group and presents
// the partial sum over a valid/ready handshake.
//   clk, rst              : clock, asynchronous active-high reset
//   prod_valid/ready/data : product beat handshake and payload
//   prod_last             : beat closes the group early
//   sum_valid/ready       : result handshake
//   sum_data              : accumulated (saturated or wrapped) sum
//   sum_count             : number of products in sum_data (1..K)
//   sum_ovf               : carry out occurred somewhere in this group
//   busy                  : a group is in progress or a result is pending
module approx_product_accumulator
  import approx_sa_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K      = 4,
  parameter bit SAT    = 1'b1,
  localparam int CNT_W = $clog2(K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_ovf,
  output logic              busy
);

  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  acc_state_t       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_beat;
  logic             ovf, ovf_nxt;
  logic             rdy_en;

  logic             accept;
  logic             start;
  logic [ACC_W-1:0] add_a, add_b, add_sum;
  logic             add_ovf;

  // rdy_en holds prod_ready low until the first edge after reset release.
  assign prod_ready = rdy_en && ((state != ST_OUT) || sum_ready);
  assign accept     = prod_valid && prod_ready;

  // A beat accepted in IDLE or OUT opens a new group: add it to zero so the
  // single adder serves the first-beat, accumulate and back-to-back paths.
  assign start = (state != ST_ACC);
  assign add_a = start ? '0 : acc;
  assign add_b = ACC_W'(prod_data);

  sat_add_u #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    cnt_beat  = start ? CNT_W'(1) : cnt + CNT_W'(1);
    if (accept) begin
      acc_nxt   = add_sum;
      cnt_nxt   = cnt_beat;
      ovf_nxt   = start ? add_ovf : (ovf | add_ovf);
      // Reaching K and prod_last on the same beat is one close.
      state_nxt = (prod_last || cnt_beat == K_CNT) ? ST_OUT : ST_ACC;
    end else if (state == ST_OUT && sum_ready) begin
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      ovf    <= ovf_nxt;
      rdy_en <= 1'b1;
    end
  end

  // acc/cnt/ovf only change on an accepted beat or a completed result
  // handshake, so the result is held for as long as it is stalled.
  assign sum_valid = (state == ST_OUT);
  assign sum_data  = acc;
  assign sum_count = cnt;
  assign sum_ovf   = ovf;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Self-checking bench: three accumulators (16-bit saturating, 9-bit
// saturating, 9-bit wrapping; K=4) share one stimulus stream. A group-level
// reference model pushes expected results into per-instance scoreboards; a
// monitor pops and compares on each result handshake.
module tb_approx_product_accumulator;

  localparam int N     = 3;
  localparam int K     = 4;
  localparam int CNT_W = $clog2(K + 1);

  typedef struct {
    int data;
    int cnt;
    int ovf;
  } exp_t;

  int cfg_w   [N] = '{16, 9, 9};
  int cfg_sat [N] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prod_valid = 1'b0;
  logic [7:0] prod_data  = '0;
  logic       prod_last  = 1'b0;
  logic       sum_ready  = 1'b0;

  logic             pr [N];
  logic             sv [N];
  logic             so [N];
  logic             bz [N];
  logic [15:0]      sd0;
  logic [8:0]       sd1, sd2;
  logic [CNT_W-1:0] sc0, sc1, sc2;
  logic [31:0]      sd [N];
  logic [31:0]      sc [N];

  assign sd[0] = 32'(sd0);
  assign sd[1] = 32'(sd1);
  assign sd[2] = 32'(sd2);
  assign sc[0] = 32'(sc0);
  assign sc[1] = 32'(sc1);
  assign sc[2] = 32'(sc2);

  always #5 clk = ~clk;

  approx_product_accumulator #(.PROD_W(8), .ACC_W(16), .K(K), .SAT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(pr[0]),
    .prod_data(prod_data), .prod_last(prod_last), .sum_valid(sv[0]),
    .sum_ready(sum_ready), .sum_data(sd0), .sum_count(sc0), .sum_ovf(so[0]),
    .busy(bz[0]));

  approx_product_accumulator #(.PROD_W(8), .ACC_W(9), .K(K), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(pr[1]),
    .prod_data(prod_data), .prod_last(prod_last), .sum_valid(sv[1]),
    .sum_ready(sum_ready), .sum_data(sd1), .sum_count(sc1), .sum_ovf(so[1]),
    .busy(bz[1]));

  approx_product_accumulator #(.PROD_W(8), .ACC_W(9), .K(K), .SAT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(pr[2]),
    .prod_data(prod_data), .prod_last(prod_last), .sum_valid(sv[2]),
    .sum_ready(sum_ready), .sum_data(sd2), .sum_count(sc2), .sum_ovf(so[2]),
    .busy(bz[2]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (group level) ----------------
  exp_t sb [N][$];
  bit   pending = 1'b0;  // a result is being presented this cycle
  int   g_sum   = 0;     // exact integer sum of the open group
  int   g_cnt   = 0;

  function automatic exp_t expect_for(input int i, input int total, input int n);
    exp_t e;
    int   lim;
    lim   = (1 << cfg_w[i]) - 1;
    e.cnt = n;
    e.ovf = (total > lim) ? 1 : 0;
    if (cfg_sat[i] != 0) e.data = (total > lim) ? lim : total;
    else                 e.data = total % (lim + 1);
    return e;
  endfunction

  // One clock cycle: drive inputs, check handshake outputs against the model,
  // then advance the model to what the coming edge must do.
  task automatic step(input bit v, input int d, input bit l, input bit sr, output bit took);
    bit exp_rdy;
    @(posedge clk);
    #2;
    prod_valid = v;
    prod_data  = 8'(d);
    prod_last  = l;
    sum_ready  = sr;
    #1;
    exp_rdy = !pending || sr;
    for (int i = 0; i < N; i++) begin
      check($sformatf("prod_ready[%0d]", i), 32'(pr[i]), 32'(exp_rdy));
      check($sformatf("sum_valid[%0d]", i), 32'(sv[i]), 32'(pending));
      check($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(pending || g_cnt > 0));
    end
    if (pending && sr) pending = 1'b0;
    took = v && exp_rdy;
    if (took) begin
      g_sum += d;
      g_cnt++;
      if (l || g_cnt == K) begin
        for (int i = 0; i < N; i++) sb[i].push_back(expect_for(i, g_sum, g_cnt));
        pending = 1'b1;
        g_sum   = 0;
        g_cnt   = 0;
      end
    end
  endtask

  task automatic beat(input int d, input bit l);
    bit t;
    step(1'b1, d, l, 1'b1, t);
  endtask

  bit held [N];
  int hd   [N];
  int hc   [N];
  int ho   [N];

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst        = 1'b1;
    prod_valid = 1'b0;
    sum_ready  = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_sum_valid[%0d]", i), 32'(sv[i]), 0);
      check($sformatf("rst_prod_ready[%0d]", i), 32'(pr[i]), 0);
      check($sformatf("rst_sum_data[%0d]", i), sd[i], 0);
      check($sformatf("rst_sum_count[%0d]", i), sc[i], 0);
      check($sformatf("rst_sum_ovf[%0d]", i), 32'(so[i]), 0);
      check($sformatf("rst_busy[%0d]", i), 32'(bz[i]), 0);
      sb[i].delete();
    end
    pending = 1'b0;
    g_sum   = 0;
    g_cnt   = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("post_rst_ready_low[%0d]", i), 32'(pr[i]), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst || !sv[i]) begin
          held[i] = 1'b0;
        end else begin
          if (held[i]) begin
            check($sformatf("stall_data[%0d]", i), sd[i], 32'(hd[i]));
            check($sformatf("stall_count[%0d]", i), sc[i], 32'(hc[i]));
            check($sformatf("stall_ovf[%0d]", i), 32'(so[i]), 32'(ho[i]));
          end
          if (sum_ready) begin
            check($sformatf("sb_nonempty[%0d]", i), 32'(sb[i].size() != 0), 1);
            if (sb[i].size() != 0) begin
              e = sb[i].pop_front();
              check($sformatf("sum_data[%0d]", i), sd[i], 32'(e.data));
              check($sformatf("sum_count[%0d]", i), sc[i], 32'(e.cnt));
              check($sformatf("sum_ovf[%0d]", i), 32'(so[i]), 32'(e.ovf));
            end
            held[i] = 1'b0;
          end else begin
            held[i] = 1'b1;
            hd[i]   = int'(sd[i]);
            hc[i]   = int'(sc[i]);
            ho[i]   = int'(so[i]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit t;
    int beats;
    for (int i = 0; i < N; i++) held[i] = 1'b0;
    do_reset();

    // Four full-scale-ish beats, continuous, closed by count.
    for (int j = 0; j < 4; j++) beat(225, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, t);

    // Early close on the second beat, then a fresh group.
    beat(9, 1'b0);
    beat(4, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, t);
    beat(3, 1'b1);

    // Result 36 stalled for 5 cycles while beats are offered, then released
    // together with a beat that opens the next group.
    for (int j = 0; j < 4; j++) beat(9, 1'b0);
    for (int j = 0; j < 5; j++) step(1'b1, 77, 1'b1, 1'b0, t);
    beat(9, 1'b0);
    beat(1, 1'b1);

    // Overflow: 765 saturates / wraps in the 9-bit instances.
    step(1'b0, 0, 1'b0, 1'b1, t);
    beat(255, 1'b0);
    beat(255, 1'b0);
    beat(255, 1'b1);
    // prod_last on the K-th beat is a single close.
    for (int j = 0; j < 3; j++) beat(200, 1'b0);
    beat(200, 1'b1);
    beat(1, 1'b1);

    // Reset mid-group discards the partial sum.
    step(1'b0, 0, 1'b0, 1'b1, t);
    beat(5, 1'b0);
    beat(6, 1'b0);
    do_reset();
    for (int j = 1; j <= 4; j++) beat(j, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, t);

    // Random throttling on both sides.
    beats = 0;
    for (int c = 0; c < 40000 && beats < 10000; c++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, t);
      if (t) beats++;
    end
    check("random_beats_done", 32'(beats >= 10000), 1);

    // Close any open group and drain.
    for (int c = 0; c < 4 && pending; c++) step(1'b0, 0, 1'b0, 1'b1, t);
    beat(0, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 0, 1'b0, 1'b1, t);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("sb_drained[%0d]", i), 32'(sb[i].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
